// File: rtl/perfect_pkg.sv
// Shared definitions for the perfect-number scan master and checker.
// Holds the handshake FSM state encoding, the default data width and the known perfect values.
package perfect_pkg;

  localparam int DEFAULT_W = 16;

  localparam int PERFECT_0 = 6;
  localparam int PERFECT_1 = 28;
  localparam int PERFECT_2 = 496;
  localparam int PERFECT_3 = 8128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    REPORT = 3'd3,
    FIN    = 3'd4
  } state_e;

endpackage

// File: rtl/perfect_scan_master_wdog.sv
// Per-check watchdog for the scan master: counts WAIT cycles and flags expiry at TMO.
// Built only when PERFECT_SCAN_TIMEOUT_EN is defined.
module scan_wdog #(
  parameter int TMO = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires on the TMO-th enabled cycle so the owner leaves WAIT at that edge.
  assign expire_o = en_i && (cnt_q == CW'(TMO - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/perfect_scan_master.sv
// Range sweeper that drives an external perfect-number checker and reports every hit.
// Optional per-check watchdog is enabled with PERFECT_SCAN_TIMEOUT_EN.
module perfect_scan_master
  import perfect_pkg::*;
#(
  parameter int W = DEFAULT_W
`ifdef PERFECT_SCAN_TIMEOUT_EN
  , parameter int TMO = 1024
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] hi,
  output logic         busy,
  output logic         done,
  output logic         hit_valid,
  output logic [W-1:0] hit_value,
  output logic [W-1:0] hit_count,
  output logic [W-1:0] chk_n,
  output logic         chk_start,
  input  logic         chk_done,
  input  logic         chk_is_perf,
  output logic         timeout
);

  state_e       state_q, state_d;
  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] hit_value_q, hit_value_d;
  logic [W-1:0] hit_count_q, hit_count_d;
  logic         verdict_q, verdict_d;
  logic         timeout_q, timeout_d;
  logic         expire;

`ifdef PERFECT_SCAN_TIMEOUT_EN
  scan_wdog #(.TMO(TMO)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == ISSUE),
    .en_i     (state_q == WAIT),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign chk_start = (state_q == ISSUE);
  assign chk_n     = cur_q;
  assign hit_valid = (state_q == REPORT) && verdict_q;
  assign hit_value = hit_value_q;
  assign hit_count = hit_count_q;
  assign timeout   = timeout_q;

  // Hit value and count are committed on the WAIT exit edge so they are valid alongside hit_valid.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    hi_d        = hi_q;
    hit_value_d = hit_value_q;
    hit_count_d = hit_count_q;
    verdict_d   = verdict_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cur_d       = lo;
          hi_d        = hi;
          hit_count_d = '0;
          timeout_d   = 1'b0;
          verdict_d   = 1'b0;
          state_d     = (lo > hi) ? FIN : ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (chk_done) begin
          verdict_d = chk_is_perf;
          if (chk_is_perf) begin
            hit_value_d = cur_q;
            hit_count_d = (&hit_count_q) ? hit_count_q : hit_count_q + 1'b1;
          end
          state_d = REPORT;
        end else if (expire) begin
          verdict_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = REPORT;
        end
      end
      // Compare before increment so a range ending at all-ones never wraps.
      REPORT: begin
        if (cur_q == hi_q) begin
          state_d = FIN;
        end else begin
          cur_d   = cur_q + 1'b1;
          state_d = ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      hi_q        <= '0;
      hit_value_q <= '0;
      hit_count_q <= '0;
      verdict_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      hi_q        <= hi_d;
      hit_value_q <= hit_value_d;
      hit_count_q <= hit_count_d;
      verdict_q   <= verdict_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_perfect_scan_master.sv
// Scoreboard bench for perfect_scan_master with a latency-randomised checker model.
// Define PERFECT_SCAN_TIMEOUT_EN to also exercise the watchdog with TMO=16.
module tb_perfect_scan_master;
  import perfect_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] lo = '0, hi = '0;
  logic        busy, done, hitValid, chkStart, timeout;
  logic [15:0] hitValue, hitCount, chkN;
  logic        chkDone = 1'b0, chkIsPerf = 1'b0;

  int checks = 0, errors = 0;
  int doneCnt = 0, doneBase = 0;
  int latMin = 1, latMax = 6, stallN = -1;
  int expChkQ[$], expHitQ[$], expDoneQ[$];

  always #5 clk = ~clk;

`ifdef PERFECT_SCAN_TIMEOUT_EN
  perfect_scan_master #(.W(16), .TMO(16)) dut (
    .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi), .busy(busy), .done(done),
    .hit_valid(hitValid), .hit_value(hitValue), .hit_count(hitCount), .chk_n(chkN),
    .chk_start(chkStart), .chk_done(chkDone), .chk_is_perf(chkIsPerf), .timeout(timeout));
`else
  perfect_scan_master #(.W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .lo(lo), .hi(hi), .busy(busy), .done(done),
    .hit_valid(hitValid), .hit_value(hitValue), .hit_count(hitCount), .chk_n(chkN),
    .chk_start(chkStart), .chk_done(chkDone), .chk_is_perf(chkIsPerf), .timeout(timeout));
`endif

  // Reference definition: n equals the sum of its proper divisors.
  function automatic bit isPerf(int n);
    int s = 0;
    if (n < 2) return 1'b0;
    for (int d = 1; d <= n / 2; d++) if (n % d == 0) s += d;
    return s == n;
  endfunction

  task automatic checkOutput(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Expectations for a whole scan are queued the moment it is requested.
  task automatic applyStimulus(int l, int h);
    int cnt = 0;
    for (int v = l; v <= h; v++) begin
      expChkQ.push_back(v);
      if (isPerf(v)) begin
        expHitQ.push_back(v);
        cnt++;
      end
    end
    expDoneQ.push_back(cnt);
    doneBase = doneCnt;
    @(posedge clk); #1;
    lo = 16'(l); hi = 16'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(int budget);
    int n = 0;
    while (doneCnt == doneBase && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", int'(doneCnt != doneBase), 1);
    @(negedge clk);
    checkOutput("busy_after_done", int'(busy), 0);
    checkOutput("chk_queue_empty", expChkQ.size(), 0);
    checkOutput("hit_queue_empty", expHitQ.size(), 0);
  endtask

  // Checker model: answers each request after a random latency unless told to stall.
  initial begin
    int n, lat;
    forever begin
      @(negedge clk);
      if (chkStart && !rst && int'(chkN) != stallN) begin
        n = int'(chkN);
        lat = $urandom_range(latMax, latMin);
        repeat (lat) @(posedge clk);
        #1 chkDone = 1'b1; chkIsPerf = isPerf(n);
        @(posedge clk);
        #1 chkDone = 1'b0; chkIsPerf = 1'b0;
      end
    end
  end

  // Monitor: pops queued expectations whenever the DUT presents a request, hit or done.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (chkStart) begin
          if (expChkQ.size() == 0) checkOutput("unexpected_chk_start", int'(chkN), -1);
          else checkOutput("chk_n", int'(chkN), expChkQ.pop_front());
        end
        if (hitValid) begin
          if (expHitQ.size() == 0) checkOutput("unexpected_hit", int'(hitValue), -1);
          else checkOutput("hit_value", int'(hitValue), expHitQ.pop_front());
        end
        if (done) begin
          doneCnt++;
          checkOutput("busy_at_done", int'(busy), 1);
          if (expDoneQ.size() == 0) checkOutput("unexpected_done", int'(hitCount), -1);
          else checkOutput("hit_count", int'(hitCount), expDoneQ.pop_front());
        end
      end
    end
  end

  initial begin
    int l, h, wd;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_hit_valid", int'(hitValid), 0);
    checkOutput("rst_chk_start", int'(chkStart), 0);
    checkOutput("rst_hit_count", int'(hitCount), 0);
    checkOutput("rst_chk_n", int'(chkN), 0);
    checkOutput("rst_timeout", int'(timeout), 0);
    @(posedge clk); #1 rst = 1'b0;

    $display("[TB] range 1..30 with an ignored mid-scan start");
    applyStimulus(1, 30);
    repeat (40) @(posedge clk);
    #1 lo = 16'd5; hi = 16'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    waitDone(600);

    $display("[TB] single value 496");
    applyStimulus(496, 496);
    waitDone(100);

    $display("[TB] empty range 10..5");
    applyStimulus(10, 5);
    @(negedge clk);
    checkOutput("empty_done_pulse", int'(done), 1);
    checkOutput("empty_busy_fin", int'(busy), 1);
    checkOutput("empty_no_chk", int'(chkStart), 0);
    @(negedge clk);
    checkOutput("empty_busy_drop", int'(busy), 0);
    waitDone(20);

    $display("[TB] top of range 0xFFFE..0xFFFF");
    applyStimulus(16'hFFFE, 16'hFFFF);
    waitDone(100);

    for (int i = 0; i < 4; i++) begin
      l = $urandom_range(60, 0);
      h = $urandom_range(60, 0);
      $display("[TB] random range %0d..%0d", l, h);
      applyStimulus(l, h);
      waitDone(1000);
    end

    $display("[TB] reset during WAIT at candidate 100");
    latMin = 12; latMax = 12;
    applyStimulus(1, 600);
    wd = 0;
    while (!(chkStart && chkN == 16'd100) && wd < 3000) begin
      @(negedge clk);
      wd++;
    end
    checkOutput("reached_cand_100", int'(chkN), 100);
    @(posedge clk); #1 rst = 1'b1;
    expChkQ.delete(); expHitQ.delete(); expDoneQ.delete();
    @(negedge clk); @(negedge clk);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_hit_count", int'(hitCount), 0);
    checkOutput("abort_chk_n", int'(chkN), 0);
    checkOutput("abort_hit_value", int'(hitValue), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("late_done_ignored", int'(busy), 0);
    latMin = 1; latMax = 6;
    applyStimulus(1, 10);
    waitDone(200);

`ifdef PERFECT_SCAN_TIMEOUT_EN
    $display("[TB] checker stalls on candidate 3");
    stallN = 3;
    applyStimulus(1, 10);
    waitDone(300);
    checkOutput("timeout_set", int'(timeout), 1);
    stallN = -1;
    applyStimulus(1, 2);
    checkOutput("timeout_cleared", int'(timeout), 0);
    waitDone(100);
`else
    checkOutput("timeout_tied", int'(timeout), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/perfect_scan_master.md
Name: perfect_scan_master

Overview:
- Initiator end of the perfect-number checker handshake.
- Sweeps an inclusive range [lo, hi], issues one check request per value to an external checker, waits for each result, and reports every perfect value found.
- Sits between the switch/host front end and the checker datapath; replaces manual single-N operation of the checker.

Parameters:
- W, 16, data width of range bounds, candidate value and hit count
- TMO, 1024, watchdog limit in cycles per check (used only with PERFECT_SCAN_TIMEOUT_EN)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a scan; sampled only in IDLE
- lo  in  W  lower bound, captured on accepted start
- hi  in  W  upper bound, captured on accepted start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at scan end
- hit_valid  out  1  one-cycle pulse per perfect value found
- hit_value  out  W  perfect value; valid while hit_valid=1
- hit_count  out  W  number of hits in the current or last scan; saturates at 2^W-1
- chk_n  out  W  candidate to checker; held stable from chk_start until chk_done
- chk_start  out  1  one-cycle request pulse to checker
- chk_done  in  1  one-cycle checker completion pulse
- chk_is_perf  in  1  checker verdict; valid only with chk_done
- timeout  out  1  sticky error flag (tied 0 without PERFECT_SCAN_TIMEOUT_EN)

Behaviour:
- Reset: state=IDLE; busy, done, hit_valid, chk_start, timeout = 0; hit_value, hit_count, chk_n = 0. Reset mid-scan aborts immediately, with no done pulse. An in-flight checker result arriving after reset is ignored.
- States:
  - IDLE: on start, latch lo/hi, clear hit_count and timeout, go to ISSUE.
  - ISSUE: chk_n=cur, chk_start=1 for exactly this cycle, go to WAIT.
  - WAIT: hold chk_n. On chk_done, capture chk_is_perf and go to REPORT.
  - REPORT:
    - If the verdict is perfect: hit_valid=1, hit_value=cur, hit_count+=1 (saturating).
    - If cur==hi, go to FIN. Otherwise cur+=1 and go to ISSUE.
  - FIN: done=1 for one cycle, busy=0 next cycle, return to IDLE.
- Per-candidate timing: ISSUE to chk_start is 0 cycles. Minimum cost per candidate is 3 cycles plus checker latency.
- First chk_start appears 1 cycle after the accepted start.
- lo>hi: IDLE -> FIN directly. No chk_start is issued; done pulses 1 cycle after start, hit_count=0.
- lo==hi: exactly one check.
- hi=2^W-1: termination uses the cur==hi compare before increment, so cur never wraps to 0.
- start while busy is ignored; lo/hi changes during a scan are ignored.
- chk_done outside WAIT is ignored (stray or late pulse).
- chk_done coincident with chk_start is impossible by protocol. WAIT is entered only after ISSUE, so a chk_done in the ISSUE cycle is ignored.
- hit_value holds the last hit between pulses. hit_count holds its value after done until the next accepted start.

Optional Feature:
- Macro PERFECT_SCAN_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT and clears on ISSUE.
  - If it reaches TMO without chk_done: set timeout=1 (sticky until next accepted start or rst), skip the candidate as not perfect, continue as if in REPORT.
  - The scan still completes with done.
- Undefined: no counter; WAIT waits indefinitely; timeout tied 0.

Decomposition:
- Shared package perfect_pkg:
  - state encoding constants (IDLE, ISSUE, WAIT, REPORT, FIN), also usable by the checker FSM
  - default W
  - known perfect constants 6, 28, 496, 8128 for benches
- One natural sub-module: scan_wdog (TMO-cycle watchdog counter with clear/enable/expire), instantiated only under PERFECT_SCAN_TIMEOUT_EN.

Test Plan:
- Range 1..30, behavioural checker model with 5-cycle latency -> hit_valid at 6 and 28, hit_count=2, exactly 30 chk_start pulses, single done pulse.
- lo=hi=496 -> one chk_start with chk_n=496, hit_value=496, hit_count=1, done 1 cycle after REPORT.
- lo=10, hi=5 -> no chk_start, done 1 cycle after start, hit_count=0, busy high for 1 cycle only.
- lo=0xFFFE, hi=0xFFFF -> exactly 2 checks (0xFFFE, 0xFFFF), no check of 0, done asserted.
- Range 1..600, rst asserted mid-WAIT at candidate 100 -> all outputs zero next cycle; late chk_done ignored; a new start on 1..10 runs normally with hit_count=1.
- With PERFECT_SCAN_TIMEOUT_EN, TMO=16, checker stalls on candidate 3 -> timeout=1 after 16 cycles in WAIT, scan continues, 6 still reported, done asserted.
